// File: rtl/display_pkg.sv
// Shared definitions for the display path.
//   SEG_WIDTH    - segment lines per digit (a..g, bit 6 = a, bit 0 = g)
//   SEG_BLANK    - active-low "all segments off" code
//   scan_state_t - scan driver FSM states
//   clog2_min1   - $clog2 that never returns 0, for index/counter widths
package display_pkg;

    localparam int SEG_WIDTH = 7;
    localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_refresh_timer.sv
// Slot counter for the display scan driver.
// Counts 0..REFRESH_DIV-1 while enabled and wraps at the end of each slot.
// When not enabled it is held at 0 so the next slot always starts cleanly.
//   clk, rst    - clock and synchronous active-high reset
//   enable      - count while high, hold at 0 while low
//   count       - current position within the slot
//   blank_phase - high while count < BLANK_CYCLES
//   slot_end    - high in the last cycle of a slot
module display_refresh_timer
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = clog2_min1(REFRESH_DIV)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             blank_phase,
    output logic             slot_end
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    assign slot_end    = (count == CNT_LAST);
    assign blank_phase = (BLANK_CYCLES > 0) && (count <= BLANK_LAST);

    // Slot counter: cleared whenever the scan is not running so a restart
    // always begins with a full blank phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!enable || slot_end) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for a multi-digit 7-segment display.
// Takes the packed active-low segment bus from the hex decoder, scans one
// digit per slot with a leading blank phase for anti-ghosting, and
// double-buffers the display data so new data only lands on frame edges.
//   clk, rst   - clock and synchronous active-high reset
//   enable     - scan enable, low keeps the display dark
//   seg_in     - packed active-low segments, digit 0 in bits 6:0
//   dp_in      - active-high decimal points, bit d for digit d
//   update     - one-cycle strobe capturing seg_in/dp_in into staging
//   seg_out    - active-low segments of the driven digit
//   dp_out     - active-low decimal point of the driven digit
//   an_out     - active-low anode enables, at most one low
//   digit_idx  - index of the current slot
//   frame_done - pulse in the final cycle of the last slot
module display_scan_driver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [NUM_DIGITS*SEG_WIDTH-1:0]      seg_in,
    input  logic [NUM_DIGITS-1:0]                dp_in,
    input  logic                                 update,
    output logic [SEG_WIDTH-1:0]                 seg_out,
    output logic                                 dp_out,
    output logic [NUM_DIGITS-1:0]                an_out,
    output logic [clog2_min1(NUM_DIGITS)-1:0]    digit_idx,
    output logic                                 frame_done
);

    localparam int IDX_W = clog2_min1(NUM_DIGITS);
    localparam int CNT_W = clog2_min1(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'((REFRESH_DIV > 1) ? REFRESH_DIV - 2 : 0);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    scan_state_t state_q, state_d, slot_start;
    logic [IDX_W-1:0] idx_d;
    logic             run;
    logic [CNT_W-1:0] count;
    logic             blank_phase;
    logic             slot_end;
    logic             frame_done_d;

    logic [SEG_WIDTH-1:0] seg_in_arr [NUM_DIGITS];
    logic [SEG_WIDTH-1:0] stage_seg   [NUM_DIGITS];
    logic [SEG_WIDTH-1:0] stage_seg_d [NUM_DIGITS];
    logic [SEG_WIDTH-1:0] act_seg     [NUM_DIGITS];
    logic [SEG_WIDTH-1:0] act_seg_d   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] stage_dp, stage_dp_d;
    logic [NUM_DIGITS-1:0] act_dp, act_dp_d;
    logic                  pending, pending_d;

    logic [NUM_DIGITS-1:0] an_d;
    logic [SEG_WIDTH-1:0]  seg_d;
    logic                  dp_d;

    // The counter only advances while already scanning; on the edge that
    // leaves IDLE it stays at 0 so slot 0 starts at count 0.
    assign run = (state_q != IDLE) && enable;

    display_refresh_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (run),
        .count       (count),
        .blank_phase (blank_phase),
        .slot_end    (slot_end)
    );

    // Unpack the decoder bus into one code per digit.
    always_comb begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
            seg_in_arr[d] = seg_in[d*SEG_WIDTH +: SEG_WIDTH];
        end
    end

    // Every slot opens in BLANK unless there is no blank phase at all.
    always_comb begin
        if (BLANK_CYCLES > 0) begin
            slot_start = BLANK;
        end else begin
            slot_start = DRIVE;
        end
    end

    // Next-state, next digit index and next frame_done. Outputs are all
    // registered, so frame_done is raised one edge ahead: when the slot
    // about to run is the last cycle of the last digit.
    always_comb begin
        state_d = state_q;
        idx_d   = digit_idx;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = slot_start;
                    idx_d   = '0;
                end
            end
            BLANK, DRIVE: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (slot_end) begin
                    state_d = slot_start;
                    idx_d   = (digit_idx == LAST_DIGIT) ? '0 : digit_idx + IDX_W'(1);
                end else if (blank_phase && (count != BLANK_LAST)) begin
                    state_d = BLANK;
                end else begin
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        frame_done_d = (state_d != IDLE) && (idx_d == LAST_DIGIT) &&
                       ((REFRESH_DIV == 1) || (run && (count == CNT_PENULT)));
    end

    // Double buffer. An update landing on the frame-end edge bypasses
    // staging so it is not delayed by a whole frame. While dark there is
    // nothing to tear, so pending data moves to active immediately.
    always_comb begin
        stage_seg_d = stage_seg;
        stage_dp_d  = stage_dp;
        act_seg_d   = act_seg;
        act_dp_d    = act_dp;
        pending_d   = pending;
        if (update && frame_done) begin
            act_seg_d   = seg_in_arr;
            act_dp_d    = dp_in;
            stage_seg_d = seg_in_arr;
            stage_dp_d  = dp_in;
            pending_d   = 1'b0;
        end else begin
            if (pending && ((state_q == IDLE) || frame_done)) begin
                act_seg_d = stage_seg;
                act_dp_d  = stage_dp;
                pending_d = 1'b0;
            end
            if (update) begin
                stage_seg_d = seg_in_arr;
                stage_dp_d  = dp_in;
                pending_d   = 1'b1;
            end
        end
    end

    // Output values for the coming cycle; only DRIVE lights an anode, and
    // only the one for the current digit.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_d == DRIVE) begin
            an_d[idx_d] = 1'b0;
            seg_d       = act_seg_d[idx_d];
            dp_d        = ~act_dp_d[idx_d];
        end
    end

    // State, buffers and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            digit_idx  <= '0;
            frame_done <= 1'b0;
            an_out     <= '1;
            seg_out    <= SEG_BLANK;
            dp_out     <= 1'b1;
            pending    <= 1'b0;
            stage_dp   <= '0;
            act_dp     <= '0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                stage_seg[d] <= SEG_BLANK;
                act_seg[d]   <= SEG_BLANK;
            end
        end else begin
            state_q    <= state_d;
            digit_idx  <= idx_d;
            frame_done <= frame_done_d;
            an_out     <= an_d;
            seg_out    <= seg_d;
            dp_out     <= dp_d;
            pending    <= pending_d;
            stage_dp   <= stage_dp_d;
            act_dp     <= act_dp_d;
            stage_seg  <= stage_seg_d;
            act_seg    <= act_seg_d;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed self-checking bench for display_scan_driver with
// NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frames).
module tb_display_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    localparam logic [27:0] D_BLANK = {4{7'h7F}};
    localparam logic [27:0] D_A821  = {7'b0001000, 7'b0000000, 7'b0010010, 7'b1001111};
    localparam logic [27:0] D_1111  = {4{7'b1001111}};
    localparam logic [27:0] D_8888  = {4{7'b0000000}};
    localparam logic [27:0] D_0000  = {4{7'b0000001}};

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [27:0] seg_in;
    logic [3:0]  dp_in;
    logic        update;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    always #5 clk = ~clk;

    display_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
        .update     (update),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic upd,
                                 input logic [27:0] s, input logic [3:0] d);
        rst    = r;
        enable = en;
        update = upd;
        seg_in = s;
        dp_in  = d;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                               input logic e_dp, input logic [1:0] e_idx, input logic e_fd);
        checkValue({tag, " an"},    32'(an_out),     32'(e_an));
        checkValue({tag, " seg"},   32'(seg_out),    32'(e_seg));
        checkValue({tag, " dp"},    32'(dp_out),     32'(e_dp));
        checkValue({tag, " idx"},   32'(digit_idx),  32'(e_idx));
        checkValue({tag, " fd"},    32'(frame_done), 32'(e_fd));
        checkValue({tag, " onehot"}, 32'($countones(~an_out) <= 1), 32'(1));
    endtask

    // Step through frame positions from..to, checking each cycle against
    // the slot layout: BC blank cycles, then the digit's code on its anode.
    task automatic runFrame(input string tag, input int from, input int to,
                            input logic [27:0] dseg, input logic [3:0] ddp);
        int slot, cnt;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        for (int c = from; c <= to; c++) begin
            tick();
            slot = c / RD;
            cnt  = c % RD;
            if (cnt < BC) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << slot);
                e_seg = dseg[slot*7 +: 7];
                e_dp  = ~ddp[slot];
            end
            checkOutput($sformatf("%s p%0d", tag, c), e_an, e_seg, e_dp, 2'(slot), (c == ND*RD-1));
        end
    endtask

    initial begin
        $display("[TB] display_scan_driver bench start");

        // 1: reset with enable held high, then free-running blank frames
        applyStimulus(1'b1, 1'b1, 1'b0, D_BLANK, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rst%0d", i), 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, D_BLANK, 4'b0000);
        runFrame("t1a", 0, 31, D_BLANK, 4'b0000);
        runFrame("t1b", 0, 31, D_BLANK, 4'b0000);

        // 2: mid-frame update shows only from the next frame
        runFrame("t2a", 0, 9, D_BLANK, 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b1, D_A821, 4'b0010);
        runFrame("t2b", 10, 10, D_BLANK, 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b0, D_BLANK, 4'b0000);
        runFrame("t2c", 11, 31, D_BLANK, 4'b0000);
        runFrame("t2d", 0, 31, D_A821, 4'b0010);

        // 3: two updates in one frame, last one wins
        runFrame("t3a", 0, 4, D_A821, 4'b0010);
        applyStimulus(1'b0, 1'b1, 1'b1, D_1111, 4'b1111);
        runFrame("t3b", 5, 5, D_A821, 4'b0010);
        applyStimulus(1'b0, 1'b1, 1'b0, D_BLANK, 4'b0000);
        runFrame("t3c", 6, 19, D_A821, 4'b0010);
        applyStimulus(1'b0, 1'b1, 1'b1, D_8888, 4'b0000);
        runFrame("t3d", 20, 20, D_A821, 4'b0010);
        applyStimulus(1'b0, 1'b1, 1'b0, D_BLANK, 4'b0000);
        runFrame("t3e", 21, 31, D_A821, 4'b0010);
        runFrame("t3f", 0, 31, D_8888, 4'b0000);

        // 4: update in the frame_done cycle bypasses into the next frame
        applyStimulus(1'b0, 1'b1, 1'b1, D_0000, 4'b0000);
        runFrame("t4a", 0, 0, D_0000, 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b0, D_BLANK, 4'b0000);
        checkValue("t4 pending", 32'(dut.pending), 32'(0));
        runFrame("t4b", 1, 31, D_0000, 4'b0000);

        // 5: enable drops in slot 2; idle update lands while dark
        runFrame("t5a", 0, 18, D_0000, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b0, D_BLANK, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("t5idle%0d", i), 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, D_1111, 4'b1000);
        tick();
        checkOutput("t5upd", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, D_BLANK, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput($sformatf("t5dark%0d", i), 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, D_BLANK, 4'b0000);
        runFrame("t5b", 0, 31, D_1111, 4'b1000);

        // 6: reset in the drive phase of slot 1 clears the active buffer
        runFrame("t6a", 0, 11, D_1111, 4'b1000);
        applyStimulus(1'b1, 1'b1, 1'b0, D_BLANK, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("t6rst%0d", i), 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, D_BLANK, 4'b0000);
        runFrame("t6b", 0, 31, D_BLANK, 4'b0000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
